// File: rtl/pipelined_writeback_pkg.sv
// Shared types and constants for the writeback stage: writeback source select,
// load funct3 encodings and the FSM state enum.
package pipelined_writeback_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2
  } wbsel_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_e;

endpackage

// File: rtl/pipelined_writeback_load_aligner.sv
// Combinational load aligner: picks the addressed byte/halfword out of the raw
// memory word and sign- or zero-extends it according to the load funct3.
module load_aligner
  import pipelined_writeback_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] raw_data,
  input  logic [1:0]        offset,
  input  logic [2:0]        funct3,
  output logic [DWIDTH-1:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    // NOTE: every combinationally written signal gets a default first, so no path can infer a latch.
    sel_byte  = raw_data[7:0];
    sel_half  = raw_data[15:0];
    load_data = raw_data;

    case (offset)
      2'd1:    sel_byte = raw_data[15:8];
      2'd2:    sel_byte = raw_data[23:16];
      2'd3:    sel_byte = raw_data[31:24];
      default: sel_byte = raw_data[7:0];
    endcase

    // Halfword loads ignore offset[0]; misalignment is not trapped.
    if (offset[1]) sel_half = raw_data[31:16];

    case (funct3)
      LB:      load_data = {{(DWIDTH-8){sel_byte[7]}}, sel_byte};
      LBU:     load_data = {{(DWIDTH-8){1'b0}}, sel_byte};
      LH:      load_data = {{(DWIDTH-16){sel_half[15]}}, sel_half};
      LHU:     load_data = {{(DWIDTH-16){1'b0}}, sel_half};
      default: load_data = raw_data;
    endcase
  end

endmodule

// File: rtl/pipelined_writeback.sv
// Registered writeback stage: accepts one retiring instruction per cycle, waits
// for load data when needed, and drives the register-file write port, PC redirect
// and retired-instruction counter.
module pipelined_writeback
  import pipelined_writeback_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 32,
  parameter int RWIDTH   = 5,
  parameter int CNTWIDTH = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [AWIDTH-1:0]   pc_i,
  input  logic [DWIDTH-1:0]   alu_res_i,
  input  logic [RWIDTH-1:0]   rd_i,
  input  logic                rd_we_i,
  input  logic [1:0]          wbsel_i,
  input  logic                brtaken_i,
  input  logic                is_load_i,
  input  logic [2:0]          ld_funct3_i,
  input  logic                flush_i,
  input  logic                mem_rsp_valid_i,
  input  logic [DWIDTH-1:0]   mem_rsp_data_i,
  output logic                wb_valid_o,
  output logic                rd_we_o,
  output logic [RWIDTH-1:0]   rd_addr_o,
  output logic [DWIDTH-1:0]   writeback_data_o,
  output logic                redirect_o,
  output logic [AWIDTH-1:0]   next_pc_o,
  output logic [CNTWIDTH-1:0] instret_o
);

  state_e state_q, state_d;

  logic [AWIDTH-1:0] pc_q;
  logic [DWIDTH-1:0] alu_q;
  logic [RWIDTH-1:0] rd_q;
  logic              rd_we_q;
  logic [1:0]        wbsel_q;
  logic              brtaken_q;
  logic [2:0]        funct3_q;

  logic accept;
  logic commit;

  assign in_ready_o = (state_q == IDLE);
  assign accept     = in_valid_i & in_ready_o & ~flush_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_load_i) state_d = WAIT_MEM;
          else           commit  = 1'b1;
        end
      end
      WAIT_MEM: begin
        // Flush wins over a same-cycle response, which is then simply dropped.
        if (flush_i) begin
          state_d = IDLE;
        end else if (mem_rsp_valid_i) begin
          state_d = IDLE;
          commit  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Non-loads commit straight from the inputs; loads commit from the latched fields.
  logic              use_in;
  logic [AWIDTH-1:0] src_pc;
  logic [DWIDTH-1:0] src_alu;
  logic [RWIDTH-1:0] src_rd;
  logic              src_we;
  logic [1:0]        src_wbsel;
  logic              src_br;
  logic [2:0]        src_funct3;

  assign use_in     = (state_q == IDLE);
  assign src_pc     = use_in ? pc_i        : pc_q;
  assign src_alu    = use_in ? alu_res_i   : alu_q;
  assign src_rd     = use_in ? rd_i        : rd_q;
  assign src_we     = use_in ? rd_we_i     : rd_we_q;
  assign src_wbsel  = use_in ? wbsel_i     : wbsel_q;
  assign src_br     = use_in ? brtaken_i   : brtaken_q;
  assign src_funct3 = use_in ? ld_funct3_i : funct3_q;

  logic [DWIDTH-1:0] load_data;

  load_aligner #(.DWIDTH(DWIDTH)) u_load_aligner (
    .raw_data  (mem_rsp_data_i),
    .offset    (src_alu[1:0]),
    .funct3    (src_funct3),
    .load_data (load_data)
  );

  logic [AWIDTH-1:0] pc_plus4;
  logic [AWIDTH-1:0] next_pc;
  logic [DWIDTH-1:0] wb_data;

  assign pc_plus4 = src_pc + AWIDTH'(4);
  assign next_pc  = src_br ? {src_alu[AWIDTH-1:1], 1'b0} : pc_plus4;

  always_comb begin
    wb_data = src_alu;
    case (src_wbsel)
      WB_MEM:  wb_data = load_data;
      WB_PC:   wb_data = DWIDTH'(pc_plus4);
      default: wb_data = src_alu;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      alu_q     <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      wbsel_q   <= '0;
      brtaken_q <= 1'b0;
      funct3_q  <= '0;
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      pc_q      <= pc_i;
      alu_q     <= alu_res_i;
      rd_q      <= rd_i;
      rd_we_q   <= rd_we_i;
      wbsel_q   <= wbsel_i;
      brtaken_q <= brtaken_i;
      funct3_q  <= ld_funct3_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_o       <= 1'b0;
      rd_we_o          <= 1'b0;
      redirect_o       <= 1'b0;
      rd_addr_o        <= '0;
      writeback_data_o <= '0;
      next_pc_o        <= '0;
      instret_o        <= '0;
    end else begin
      wb_valid_o <= commit;
      rd_we_o    <= commit & src_we & (src_rd != '0);
      redirect_o <= commit & src_br;
      // Data/address outputs hold between commits.
      if (commit) begin
        rd_addr_o        <= src_rd;
        writeback_data_o <= wb_data;
        next_pc_o        <= next_pc;
        instret_o        <= instret_o + CNTWIDTH'(1);
      end
    end
  end

endmodule

// File: doc/pipelined_writeback.md
Name: pipelined_writeback

Overview:
Registered writeback stage for the pipelined core. It accepts one retiring instruction per cycle from the MEM stage through a valid/ready handshake. Loads wait for a variable-latency data-memory response, which is aligned and sign/zero-extended before commit. The stage drives the register-file write port and the PC redirect, and keeps a retired-instruction counter.

Parameters:
DWIDTH, 32, data width (word = 4 bytes; must be 32)
AWIDTH, 32, PC/address width
RWIDTH, 5, register index width
CNTWIDTH, 64, instret counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid_i  in  1  MEM stage presents an instruction
in_ready_o  out  1  stage can accept (combinational: state==IDLE)
pc_i  in  AWIDTH  instruction PC
alu_res_i  in  DWIDTH  ALU result / branch target / load address
rd_i  in  RWIDTH  destination register
rd_we_i  in  1  instruction writes rd
wbsel_i  in  2  writeback source (WB_ALU/WB_MEM/WB_PC)
brtaken_i  in  1  branch/jump taken
is_load_i  in  1  instruction is a load
ld_funct3_i  in  3  load type
flush_i  in  1  squash in-flight/incoming instruction
mem_rsp_valid_i  in  1  load data valid
mem_rsp_data_i  in  DWIDTH  raw aligned-word load data
wb_valid_o  out  1  one-cycle commit pulse
rd_we_o  out  1  register-file write enable
rd_addr_o  out  RWIDTH  register-file write index
writeback_data_o  out  DWIDTH  register-file write data
redirect_o  out  1  PC redirect pulse
next_pc_o  out  AWIDTH  committed next PC
instret_o  out  CNTWIDTH  retired count

Behaviour:
- Reset (async, active-high): state IDLE. All outputs 0. instret_o 0. Latched fields cleared. Reset mid-load abandons the load; no commit.
- FSM states: IDLE, WAIT_MEM.
- Accept = in_valid_i & in_ready_o & !flush_i. Latch pc, alu_res, rd, rd_we, wbsel, brtaken, funct3, and byte offset alu_res_i[1:0].
- IDLE, accept non-load: commit on the next edge (latency 1). Stay IDLE, so back-to-back non-loads run at 1/cycle.
- IDLE, accept load: go to WAIT_MEM. in_ready_o=0.
- WAIT_MEM, mem_rsp_valid_i=1: commit on the next edge; go to IDLE.
- mem_rsp_valid_i while in IDLE is ignored. A response in the acceptance cycle is ignored; memory latency is at least 1 cycle.
- flush_i has the highest priority:
  - In IDLE it blocks acceptance.
  - In WAIT_MEM it returns to IDLE with no commit. A response in the same cycle is discarded.
  - It does not cancel a commit already registered on the outputs.
- Commit (registered outputs, valid for exactly one cycle):
  - wb_valid_o=1.
  - rd_we_o = rd_we & (rd != 0).
  - rd_addr_o = rd.
  - redirect_o = brtaken.
  - next_pc_o = brtaken ? {alu_res[AWIDTH-1:1],1'b0} : pc+4. Modulo 2^AWIDTH; 0xFFFFFFFC+4 wraps to 0.
  - writeback_data_o by wbsel: WB_ALU → alu_res; WB_MEM → aligned load data; WB_PC → pc+4; 2'b11 → alu_res.
- Non-commit cycles: wb_valid_o, rd_we_o, redirect_o are 0. Data/address outputs hold their last value.
- Load alignment:
  - LB/LBU select byte offset[1:0]. LH/LHU select halfword offset[1]; offset[0] is ignored and misalignment is not trapped.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW and undefined funct3 pass the word unchanged.
- instret_o increments by 1 on each commit and wraps at 2^CNTWIDTH. It does not increment on flush.

Decomposition:
- Shared package: wbsel enum (WB_ALU=0, WB_MEM=1, WB_PC=2), load funct3 constants (LB=000, LH=001, LW=010, LBU=100, LHU=101), FSM state enum.
- Sub-module: load_aligner, combinational (raw word, offset, funct3 → extended data).

Test Plan:
- ALU op pc=0x100, alu_res=0x1234, rd=5, wbsel=WB_ALU → next cycle wb_valid_o=1, rd_we_o=1, rd_addr_o=5, writeback_data_o=0x1234, next_pc_o=0x104, instret_o=1.
- LB, alu_res=0x2003, response 0x80FF_0000 after 3 cycles → in_ready_o=0 for 3 cycles; commit writeback_data_o=0xFFFF_FF80. Repeat as LBU → 0x0000_0080.
- LH offset 2 with data 0x8001_1234 → 0xFFFF_8001. LHU → 0x0000_8001. LW → 0x8001_1234.
- JALR, brtaken=1, alu_res=0x0000_2001, pc=0x40, wbsel=WB_PC → redirect_o=1, next_pc_o=0x2000, writeback_data_o=0x44.
- Load accepted, flush_i in WAIT_MEM, response next cycle → no wb_valid_o, instret unchanged, in_ready_o=1 after flush. rd=0 ALU op → wb_valid_o=1, rd_we_o=0.
- 4 back-to-back non-loads → 4 consecutive commit pulses. Assert reset during a later load wait → all outputs and instret_o go to 0 immediately.
